// File: rtl/imem_loader.sv
// imem_loader: streams big-endian bytes into instruction memory words, then releases the CPU
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h00400000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        cpu_reset,
  output logic        cpu_load_pc,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, RELEASE, DONE} state_t;
  state_t      state;
  logic [15:0] wc;
  logic [31:0] index;
  logic [1:0]  bidx;
  logic        legal;
  assign legal = (word_count != 16'd0) && (int'(word_count) <= MAX_WORDS);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wc          <= '0;
      index       <= '0;
      bidx        <= '0;
      byte_ready  <= 1'b0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= BASE_ADDR;
      mem_din     <= '0;
      cpu_reset   <= 1'b1;
      cpu_load_pc <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          if (legal) begin
            state      <= RECV;
            wc         <= word_count;
            index      <= '0;
            bidx       <= '0;
            mem_addr   <= BASE_ADDR;
            byte_ready <= 1'b1;
            cpu_reset  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
          end else error <= 1'b1;
        end
        // shifting left four times leaves the first byte in [31:24]
        RECV: if (byte_valid) begin
          mem_din <= {mem_din[23:0], byte_data};
          bidx    <= bidx + 2'd1;
          if (bidx == 2'd3) begin
            state      <= WRITE;
            byte_ready <= 1'b0;
            mem_cs     <= 1'b1;
            mem_we     <= 1'b1;
          end
        end
        WRITE: begin
          mem_cs   <= 1'b0;
          mem_we   <= 1'b0;
          index    <= index + 32'd1;
          mem_addr <= mem_addr + 32'd4;
          bidx     <= '0;
          if (index + 32'd1 == {16'd0, wc}) begin
            state       <= RELEASE;
            cpu_reset   <= 1'b0;
            cpu_load_pc <= 1'b1;
          end else begin
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end
        RELEASE: begin
          state       <= DONE;
          cpu_load_pc <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random and directed loads checked by a write scoreboard
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h00400000;
  localparam int MAXW = 16;
  logic clk = 1'b0, reset, start, byte_valid;
  logic [15:0] word_count;
  logic [7:0] byte_data;
  logic byte_ready, mem_cs, mem_we, cpu_reset, cpu_load_pc, busy, done, error;
  logic [31:0] mem_addr, mem_din;
  int checks = 0, failures = 0, n_wr = 0, n_lpc = 0;
  logic [63:0] q[$];
  logic [31:0] ws[$];

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .cpu_reset(cpu_reset), .cpu_load_pc(cpu_load_pc), .busy(busy), .done(done),
    .error(error));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (reset) begin
    if (mem_cs !== mem_we) chk("cs_we_match", mem_cs, mem_we);
    if (mem_we) begin
      n_wr++;
      if (q.size() == 0) chk("unexpected_write", mem_we, 0);
      else begin
        logic [63:0] e;
        e = q.pop_front();
        chk("wr_addr", mem_addr, e[63:32]);
        chk("wr_data", mem_din, e[31:0]);
        chk("wr_ready_low", byte_ready, 0);
      end
    end
    if (cpu_load_pc) begin
      n_lpc++;
      chk("lpc_cpu_reset", cpu_reset, 0);
    end
  end

  task automatic chk_reset_vals();
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_load_pc", cpu_load_pc, 0);
    chk("rst_cs_we", {mem_cs, mem_we}, 0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_din", mem_din, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_status", {busy, done, error}, 0);
  endtask

  task automatic pulse_start(input int wc, input bit valid_too);
    start = 1'b1;
    word_count = 16'(wc);
    byte_valid = valid_too;
    byte_data = 8'hEE;
    @(posedge clk); #1;
    start = 1'b0;
    byte_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    logic rdy;
    byte_valid = 1'b1;
    byte_data = b;
    do begin
      @(negedge clk); rdy = byte_ready;
      @(posedge clk); #1;
      t++;
    end while (!rdy && t < 100);
    if (!rdy) chk("byte_accept_timeout", byte_ready, 1);
  endtask

  task automatic send_word(input logic [31:0] d, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      if (gaps) begin
        byte_valid = 1'b0;
        @(posedge clk); #1;
      end
      send_byte(d[31-8*k -: 8]);
    end
    byte_valid = 1'b0;
    @(negedge clk);
    chk("write_latency", mem_we, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_load(input bit gaps, input bit valid_too, input int mid_start);
    int wr0 = n_wr, lpc0 = n_lpc, t = 0, wc = ws.size();
    pulse_start(wc, valid_too);
    chk("start_busy", busy, 1);
    chk("start_cpu_reset", cpu_reset, 1);
    chk("start_done_err", {done, error}, 0);
    for (int w = 0; w < wc; w++) begin
      q.push_back({BASE + 32'(4 * w), ws[w]});
      if (w == mid_start) begin
        start = 1'b1;
        word_count = 16'd1;
      end
      send_word(ws[w], gaps);
      start = 1'b0;
    end
    while (!done && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("end_done", done, 1);
    chk("end_cpu_reset", cpu_reset, 0);
    chk("end_busy", busy, 0);
    chk("end_writes", n_wr - wr0, wc);
    chk("end_load_pc_pulses", n_lpc - lpc0, 1);
    chk("end_queue_empty", q.size(), 0);
  endtask

  task automatic rand_words(input int n);
    ws = {};
    for (int i = 0; i < n; i++) ws.push_back($urandom);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; word_count = 16'd0;
    #23;
    chk_reset_vals();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    pulse_start(0, 0);
    chk("err_zero", error, 1);
    chk("err_zero_state", {busy, cpu_reset, byte_ready}, 3'b010);
    pulse_start(MAXW + 1, 0);
    chk("err_over", error, 1);
    chk("err_over_state", {busy, cpu_reset, byte_ready}, 3'b010);
    ws = {32'h20080005, 32'h0000000C};
    do_load(0, 0, -1);
    pulse_start(0, 0);
    chk("err_in_done", {error, done, cpu_reset}, 3'b110);
    rand_words(1);
    do_load(1, 1, -1);
    rand_words(2);
    do_load(0, 0, 1);
    rand_words(1);
    pulse_start(1, 0);
    for (int k = 0; k < 3; k++) send_byte(ws[0][31-8*k -: 8]);
    byte_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", {busy, done, cpu_reset}, 3'b001);
    do_load(0, 0, -1);
    ws = {};
    for (int i = 0; i < MAXW; i++) ws.push_back($urandom);
    do_load(1'($urandom), 0, -1);
    for (int r = 0; r < 4; r++) begin
      rand_words($urandom_range(1, MAXW));
      do_load(1'($urandom), 1'($urandom), -1);
    end
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h00400000, which is the byte address of the first instruction-memory word written.
REQ-002 The block SHALL have parameter MAX_WORDS, default 1024, which is the largest legal word_count.
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit, asynchronous active-low reset.
REQ-005 Port start SHALL be an input, 1 bit, a request to begin a load, sampled only in IDLE or DONE.
REQ-006 Port word_count SHALL be an input, 16 bits, the number of 32-bit words to load, captured on an accepted start.
REQ-007 Port byte_valid SHALL be an input, 1 bit, indicating the source presents byte_data.
REQ-008 Port byte_data SHALL be an input, 8 bits, the image byte stream.
REQ-009 Port byte_ready SHALL be an output, 1 bit, indicating the loader accepts a byte this cycle.
REQ-010 Ports mem_cs and mem_we SHALL be outputs, 1 bit each, the instruction-memory chip select and write enable.
REQ-011 Port mem_addr SHALL be an output, 32 bits, the byte address to instruction memory.
REQ-012 Port mem_din SHALL be an output, 32 bits, the write data to instruction memory.
REQ-013 Port cpu_reset SHALL be an output, 1 bit, active-high hold of the processor reset.
REQ-014 Port cpu_load_pc SHALL be an output, 1 bit, the processor PC reload strobe.
REQ-015 Ports busy, done and error SHALL be outputs, 1 bit each, carrying loader status.

Function
REQ-016 The block SHALL use the states IDLE, RECV, WRITE, RELEASE and DONE.
REQ-017 IDLE/DONE + start=1:
- word_count in 1..MAX_WORDS -> capture it, clear error and done, set address offset=0 and byte index=0, go to RECV.
- otherwise -> set error=1 and stay in the current state.
REQ-018 start SHALL be ignored in RECV, WRITE and RELEASE.
REQ-019 Byte handshake: byte_ready=1 only in RECV; a byte is accepted when byte_valid and byte_ready are both 1 on a rising edge.
REQ-020 Byte packing SHALL be big-endian: the 1st accepted byte goes to mem_din[31:24], the 2nd to [23:16], the 3rd to [15:8] and the 4th to [7:0].
REQ-021 On acceptance of the 4th byte the block SHALL go to WRITE.
REQ-022 WRITE SHALL last exactly 1 cycle with mem_cs=1, mem_we=1, mem_addr=BASE_ADDR+4*index and mem_din holding the assembled word.
REQ-023 Outside WRITE, mem_we SHALL be 0 and mem_cs SHALL be 0.
REQ-024 After WRITE, index increments by 1 (32-bit addition, wraps modulo 2^32); if index equals word_count the block goes to RELEASE, else to RECV with byte index 0.
REQ-025 Latency SHALL be a write cycle exactly 1 cycle after the 4th byte of each word is accepted; the maximum throughput is 4 bytes per 5 cycles.
REQ-026 RELEASE SHALL last 1 cycle with cpu_load_pc=1 and cpu_reset=0, then go to DONE.
REQ-027 In DONE: done=1, cpu_reset=0, cpu_load_pc=0.
REQ-028 cpu_reset SHALL be 1 in IDLE, RECV and WRITE, and SHALL re-assert on the cycle after a reload start is accepted in DONE.
REQ-029 busy SHALL be 1 in RECV, WRITE and RELEASE, and 0 otherwise.
REQ-030 error SHALL be sticky until the next accepted legal start or reset.
REQ-031 byte_valid without byte_ready SHALL have no effect, and bytes are never dropped or duplicated.
REQ-032 start together with byte_valid in IDLE SHALL not accept that byte; the first byte is accepted no earlier than the first RECV cycle.

Reset
REQ-033 reset=0 SHALL immediately force: state IDLE, cpu_reset=1, cpu_load_pc=0, mem_cs=0, mem_we=0, mem_addr=BASE_ADDR, mem_din=0, byte_ready=0, busy=0, done=0, error=0, index=0, byte index=0.
REQ-034 Reset mid-load SHALL abandon the partial word with no write issued; a fresh start is required afterwards.
REQ-035 Deassertion of reset SHALL take effect at the next rising clk edge, with no glitch on mem_we.

Verification
REQ-036 Scenario: start with word_count=2, then bytes 8'h20,08,00,05,8'h00,00,00,0C sent back-to-back -> writes 32'h20080005 at 32'h00400000 and 32'h0000000C at 32'h00400004, then a 1-cycle cpu_load_pc, then done=1 and cpu_reset=0.
REQ-037 Scenario: word_count=1 with byte_valid toggling every other cycle -> exactly one write of the correctly packed word, and byte_ready=0 during WRITE.
REQ-038 Scenario: word_count=0 or word_count=MAX_WORDS+1 -> error=1, no write, state unchanged, cpu_reset remains 1.
REQ-039 Scenario: reset=0 asserted after 3 bytes of word 0 -> no mem_we pulse and all outputs at reset values; then word_count=1 loads from BASE_ADDR.
REQ-040 Scenario: start pulsed during RECV -> ignored, and word_count is not recaptured.
REQ-041 Scenario: start in DONE with word_count=1 -> cpu_reset=1 and done=0 on the next cycle, with the reload writing at BASE_ADDR.
